// File: rtl/serial_operand_serializer.sv
// serial_operand_serializer
// Takes an A/B operand pair over a valid/ready handshake and streams both
// words out LSB-first, one bit of each per beat. `first` clears the carry of
// the downstream serial adder; `last` tells the collector the word is done.
// A new pair can be taken on the last beat of the current word, so
// back-to-back words stream with no idle beat.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | no word in flight; in_ready high, outputs forced to zero
//   S_SHIFT | word in flight; a_sh[0]/b_sh[0] presented, cnt = bit index

module serial_operand_serializer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a_word,
   input  logic [W-1:0] b_word,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         a_bit,
   output logic         b_bit,
   output logic         first,
   output logic         last
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [W-1:0]    r_a_sh;
   logic [W-1:0]    r_b_sh;
   logic [CW-1:0]   r_cnt;

   logic            w_shift;
   logic            w_at_last;
   logic            w_beat_done;
   logic            w_accept;

   assign w_shift     = (r_state == S_SHIFT);
   assign w_at_last   = (r_cnt == LAST_CNT);
   assign w_beat_done = w_shift & out_ready;
   assign w_accept    = in_valid & in_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: leave SHIFT only when the last beat drains with no new pair waiting.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (out_ready && w_at_last && !in_valid) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs: data qualifiers masked to zero outside SHIFT; in_ready may
   // follow out_ready combinationally on the last beat to allow zero-bubble reload.
   always_comb begin
      in_ready  = ~rst & (~w_shift | (w_at_last & out_ready));
      out_valid = w_shift;
      a_bit     = w_shift & r_a_sh[0];
      b_bit     = w_shift & r_b_sh[0];
      first     = w_shift & (r_cnt == '0);
      last      = w_shift & w_at_last;
   end

   // Datapath: load on accept, shift and count on each consumed non-last beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sh <= '0;
         r_b_sh <= '0;
         r_cnt  <= '0;
      end else if (w_accept) begin
         r_a_sh <= a_word;
         r_b_sh <= b_word;
         r_cnt  <= '0;
      end else if (w_beat_done && !w_at_last) begin
         r_a_sh <= r_a_sh >> 1;
         r_b_sh <= r_b_sh >> 1;
         r_cnt  <= r_cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Bench for serial_operand_serializer: a W=8 and a W=1 instance checked
// against a beat-queue model. Each accepted pair expands into W beats
// {a[i], b[i], i==0, i==W-1}; the head of the queue is the expected output.

module tb_serial_operand_serializer;

   logic       clk = 1'b0;
   logic       rst;

   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] a_word, b_word;
   logic       a_bit, b_bit, first, last;

   logic       in_valid_1, in_ready_1, out_valid_1, out_ready_1;
   logic [0:0] a_word_1, b_word_1;
   logic       a_bit_1, b_bit_1, first_1, last_1;

   int n_err = 0;
   int n_chk = 0;

   typedef struct packed {
      logic a;
      logic b;
      logic f;
      logic l;
   } beat_t;

   beat_t q8[$];
   beat_t q1[$];

   always #5 clk = ~clk;

   serial_operand_serializer #(.W(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a_word(a_word), .b_word(b_word),
      .out_valid(out_valid), .out_ready(out_ready),
      .a_bit(a_bit), .b_bit(b_bit), .first(first), .last(last)
   );

   serial_operand_serializer #(.W(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_1), .in_ready(in_ready_1),
      .a_word(a_word_1), .b_word(b_word_1),
      .out_valid(out_valid_1), .out_ready(out_ready_1),
      .a_bit(a_bit_1), .b_bit(b_bit_1), .first(first_1), .last(last_1)
   );

   // Expected {in_ready, out_valid, a, b, first, last}: idle when the queue is
   // empty; ready mid-stream only when the head is the word's final beat and consumed.
   function automatic logic [5:0] exp8(input logic ordy);
      logic ir;
      if (q8.size() == 0) return 6'b100000;
      ir = (q8.size() == 1) && ordy;
      return {ir, 1'b1, q8[0]};
   endfunction

   function automatic logic [5:0] exp1(input logic ordy);
      logic ir;
      if (q1.size() == 0) return 6'b100000;
      ir = (q1.size() == 1) && ordy;
      return {ir, 1'b1, q1[0]};
   endfunction

   task automatic m8_update(input logic acc, input logic pop, input logic [7:0] a, input logic [7:0] b);
      beat_t bt;
      if (pop) void'(q8.pop_front());
      if (acc) begin
         for (int i = 0; i < 8; i++) begin
            bt.a = a[i]; bt.b = b[i]; bt.f = (i == 0); bt.l = (i == 7);
            q8.push_back(bt);
         end
      end
   endtask

   task automatic m1_update(input logic acc, input logic pop, input logic a, input logic b);
      beat_t bt;
      if (pop) void'(q1.pop_front());
      if (acc) begin
         bt.a = a; bt.b = b; bt.f = 1'b1; bt.l = 1'b1;
         q1.push_back(bt);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1; a_word = 8'h5A; b_word = 8'hC3; out_ready = 1'b1;
      in_valid_1 = 1'b1; a_word_1 = 1'b1; b_word_1 = 1'b1; out_ready_1 = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_chk++;
         if ({in_ready, out_valid, in_ready_1, out_valid_1} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_hold cyc=%0d got={ir,ov,ir1,ov1}=%b want=0000", c,
                     {in_ready, out_valid, in_ready_1, out_valid_1});
         end
         @(posedge clk); #1;
      end
      rst = 1'b0; in_valid = 1'b0; in_valid_1 = 1'b0;
      q8.delete(); q1.delete();
      @(negedge clk);
      n_chk++;
      if ({in_ready, out_valid, a_bit, b_bit, first, last} !== 6'b100000) begin
         n_err++;
         $display("FAIL reset_release got=%b want=100000", {in_ready, out_valid, a_bit, b_bit, first, last});
      end
      n_chk++;
      if ({in_ready_1, out_valid_1, a_bit_1, b_bit_1, first_1, last_1} !== 6'b100000) begin
         n_err++;
         $display("FAIL reset_release_w1 got=%b want=100000",
                  {in_ready_1, out_valid_1, a_bit_1, b_bit_1, first_1, last_1});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [5:0] act, expv;
      logic acc, pop;
      logic [7:0] sa, sb, sf, sl;
      int nb = 0;
      sa = '0; sb = '0; sf = '0; sl = '0;
      a_word = 8'h3C; b_word = 8'hA5; out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         in_valid = (c == 0);
         @(negedge clk);
         expv = exp8(out_ready);
         act  = {in_ready, out_valid, a_bit, b_bit, first, last};
         n_chk++;
         if (act !== expv) begin
            n_err++;
            $display("FAIL basic_beat cyc=%0d got=%b want=%b", c, act, expv);
         end
         acc = in_valid & expv[5];
         pop = expv[4] & out_ready;
         if (pop && nb < 8) begin
            sa[nb] = a_bit; sb[nb] = b_bit; sf[nb] = first; sl[nb] = last;
            nb++;
         end
         @(posedge clk); #1;
         m8_update(acc, pop, a_word, b_word);
      end
      n_chk++;
      if ({sa, sb, sf, sl} !== {8'h3C, 8'hA5, 8'h01, 8'h80} || nb != 8) begin
         n_err++;
         $display("FAIL basic_seq got a=%h b=%h f=%h l=%h beats=%0d want a=3c b=a5 f=01 l=80 beats=8",
                  sa, sb, sf, sl, nb);
      end
   endtask

   task automatic test_backpressure();
      logic [5:0] act, expv;
      logic acc, pop;
      logic [7:0] sa, sb;
      int nb = 0, s2 = 0, s5 = 0, vcnt = 0, bcnt = 0;
      sa = '0; sb = '0;
      a_word = 8'h3C; b_word = 8'hA5;
      for (int c = 0; c < 20; c++) begin
         in_valid  = (c == 0);
         out_ready = !((q8.size() != 0) && ((nb == 2 && s2 < 3) || (nb == 5 && s5 < 3)));
         if (!out_ready && nb == 2) s2++;
         if (!out_ready && nb == 5) s5++;
         @(negedge clk);
         expv = exp8(out_ready);
         act  = {in_ready, out_valid, a_bit, b_bit, first, last};
         n_chk++;
         if (act !== expv) begin
            n_err++;
            $display("FAIL bp_beat cyc=%0d got=%b want=%b", c, act, expv);
         end
         if (out_valid === 1'b1) vcnt++;
         if (out_valid === 1'b1 && out_ready) bcnt++;
         acc = in_valid & expv[5];
         pop = expv[4] & out_ready;
         if (pop && nb < 8) begin
            sa[nb] = a_bit; sb[nb] = b_bit;
            nb++;
         end
         @(posedge clk); #1;
         m8_update(acc, pop, a_word, b_word);
      end
      out_ready = 1'b1;
      n_chk++;
      if (vcnt != 14 || bcnt != 8 || sa !== 8'h3C || sb !== 8'hA5) begin
         n_err++;
         $display("FAIL bp_totals got valid=%0d beats=%0d a=%h b=%h want valid=14 beats=8 a=3c b=a5",
                  vcnt, bcnt, sa, sb);
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] act, expv;
      logic acc, pop;
      logic [15:0] sa, sb, sf, sl;
      int nb = 0, p = 0, vcnt = 0, fv = -1, lv = -1, acc_beat = -1;
      sa = '0; sb = '0; sf = '0; sl = '0;
      out_ready = 1'b1;
      for (int c = 0; c < 22; c++) begin
         in_valid = (p < 2);
         a_word = (p == 0) ? 8'hFF : 8'h80;
         b_word = (p == 0) ? 8'h01 : 8'h80;
         @(negedge clk);
         expv = exp8(out_ready);
         act  = {in_ready, out_valid, a_bit, b_bit, first, last};
         n_chk++;
         if (act !== expv) begin
            n_err++;
            $display("FAIL b2b_beat cyc=%0d got=%b want=%b", c, act, expv);
         end
         if (out_valid === 1'b1) begin
            vcnt++;
            if (fv < 0) fv = c;
            lv = c;
         end
         acc = in_valid & expv[5];
         pop = expv[4] & out_ready;
         if (acc && expv[4]) acc_beat = nb;
         if (pop && nb < 16) begin
            sa[nb] = a_bit; sb[nb] = b_bit; sf[nb] = first; sl[nb] = last;
            nb++;
         end
         @(posedge clk); #1;
         m8_update(acc, pop, a_word, b_word);
         if (acc) p++;
      end
      in_valid = 1'b0;
      n_chk++;
      if (acc_beat != 7 || vcnt != 16 || (lv - fv + 1) != 16) begin
         n_err++;
         $display("FAIL b2b_timing got accept_beat=%0d valid=%0d span=%0d want 7 16 16",
                  acc_beat, vcnt, lv - fv + 1);
      end
      n_chk++;
      if ({sa, sb, sf, sl} !== {16'h80FF, 16'h8001, 16'h0101, 16'h8080}) begin
         n_err++;
         $display("FAIL b2b_seq got a=%h b=%h f=%h l=%h want a=80ff b=8001 f=0101 l=8080", sa, sb, sf, sl);
      end
   endtask

   task automatic test_reset_mid();
      logic [5:0] act, expv;
      logic acc, pop;
      logic [7:0] sa, sb, sf;
      int nb = 0;
      sa = '0; sb = '0; sf = '0;
      out_ready = 1'b1;
      for (int c = 0; c < 16; c++) begin
         rst      = (c == 4);
         in_valid = (c == 0) || (c == 5);
         a_word   = (c == 0) ? 8'hAA : 8'h0F;
         b_word   = (c == 0) ? 8'($urandom) : 8'hF0;
         @(negedge clk);
         if (c == 4) begin
            n_chk++;
            if (in_ready !== 1'b0) begin
               n_err++;
               $display("FAIL midrst_ready got=%b want=0", in_ready);
            end
            @(posedge clk); #1;
            q8.delete();
         end else begin
            expv = exp8(out_ready);
            act  = {in_ready, out_valid, a_bit, b_bit, first, last};
            n_chk++;
            if (act !== expv) begin
               n_err++;
               $display("FAIL midrst_beat cyc=%0d got=%b want=%b", c, act, expv);
            end
            acc = in_valid & expv[5];
            pop = expv[4] & out_ready;
            if (pop && c > 5 && nb < 8) begin
               sa[nb] = a_bit; sb[nb] = b_bit; sf[nb] = first;
               nb++;
            end
            @(posedge clk); #1;
            m8_update(acc, pop, a_word, b_word);
         end
      end
      rst = 1'b0; in_valid = 1'b0;
      n_chk++;
      if ({sa, sb, sf} !== {8'h0F, 8'hF0, 8'h01} || nb != 8) begin
         n_err++;
         $display("FAIL midrst_seq got a=%h b=%h f=%h beats=%0d want a=0f b=f0 f=01 beats=8", sa, sb, sf, nb);
      end
   endtask

   task automatic test_random();
      logic [5:0] act, expv;
      logic acc, pop;
      int left = 30;
      bit done = 0;
      in_valid = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         if (!in_valid && left > 0 && ($urandom % 3) != 0) begin
            in_valid = 1'b1; a_word = 8'($urandom); b_word = 8'($urandom);
         end
         out_ready = (($urandom % 4) != 0);
         @(negedge clk);
         expv = exp8(out_ready);
         act  = {in_ready, out_valid, a_bit, b_bit, first, last};
         n_chk++;
         if (act !== expv) begin
            n_err++;
            $display("FAIL rand_beat cyc=%0d got=%b want=%b", c, act, expv);
         end
         acc = in_valid & expv[5];
         pop = expv[4] & out_ready;
         @(posedge clk); #1;
         m8_update(acc, pop, a_word, b_word);
         if (acc) begin
            in_valid = 1'b0;
            left--;
         end
         done = (left == 0) && (q8.size() == 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_chk++;
      if (!done) begin
         n_err++;
         $display("FAIL rand_timeout got words_left=%0d queued=%0d want 0 0", left, q8.size());
      end
   endtask

   task automatic test_w1();
      logic [5:0] act, expv;
      logic acc, pop;
      logic [1:0] sa, sb;
      int nb = 0, p = 0, left = 20;
      bit done = 0;
      sa = '0; sb = '0;
      out_ready_1 = 1'b1;
      for (int c = 0; c < 5; c++) begin
         in_valid_1 = (p < 2);
         a_word_1   = 1'b1;
         b_word_1   = (p == 1);
         @(negedge clk);
         expv = exp1(out_ready_1);
         act  = {in_ready_1, out_valid_1, a_bit_1, b_bit_1, first_1, last_1};
         n_chk++;
         if (act !== expv) begin
            n_err++;
            $display("FAIL w1_beat cyc=%0d got=%b want=%b", c, act, expv);
         end
         if (expv[4]) begin
            n_chk++;
            if ({first_1, last_1, in_ready_1} !== 3'b111) begin
               n_err++;
               $display("FAIL w1_flags cyc=%0d got={f,l,ir}=%b want=111", c, {first_1, last_1, in_ready_1});
            end
         end
         acc = in_valid_1 & expv[5];
         pop = expv[4] & out_ready_1;
         if (pop && nb < 2) begin
            sa[nb] = a_bit_1; sb[nb] = b_bit_1;
            nb++;
         end
         @(posedge clk); #1;
         m1_update(acc, pop, a_word_1, b_word_1);
         if (acc) p++;
      end
      n_chk++;
      if (sa !== 2'b11 || sb !== 2'b10 || nb != 2) begin
         n_err++;
         $display("FAIL w1_seq got a=%b b=%b beats=%0d want a=11 b=10 beats=2", sa, sb, nb);
      end
      in_valid_1 = 1'b0;
      for (int c = 0; c < 1000 && !done; c++) begin
         if (!in_valid_1 && left > 0 && ($urandom % 2) != 0) begin
            in_valid_1 = 1'b1; a_word_1 = 1'($urandom); b_word_1 = 1'($urandom);
         end
         out_ready_1 = (($urandom % 3) != 0);
         @(negedge clk);
         expv = exp1(out_ready_1);
         act  = {in_ready_1, out_valid_1, a_bit_1, b_bit_1, first_1, last_1};
         n_chk++;
         if (act !== expv) begin
            n_err++;
            $display("FAIL w1_rand cyc=%0d got=%b want=%b", c, act, expv);
         end
         acc = in_valid_1 & expv[5];
         pop = expv[4] & out_ready_1;
         @(posedge clk); #1;
         m1_update(acc, pop, a_word_1, b_word_1);
         if (acc) begin
            in_valid_1 = 1'b0;
            left--;
         end
         done = (left == 0) && (q1.size() == 0);
      end
      in_valid_1 = 1'b0;
      n_chk++;
      if (!done) begin
         n_err++;
         $display("FAIL w1_timeout got words_left=%0d queued=%0d want 0 0", left, q1.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_w1();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/serial_operand_serializer.md
Name: serial_operand_serializer

Overview:
- Upstream feeder for the bit-serial adder datapath.
- Accepts a pair of W-bit operands over a valid/ready handshake and emits them LSB-first, one bit of each per beat, on a valid/ready stream.
- Marks the first and last beat of each word. `first` is the carry-clear qualifier for the downstream serial adder; `last` marks word completion for the downstream collector.
- Supports zero-bubble back-to-back words: sustained throughput is one operand pair per W cycles.

Parameters:
- W, default 8: operand width in bits; legal range W >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand pair a_word/b_word is presented.
- in_ready  output  1  block can accept a pair this cycle.
- a_word  input  W  operand A, sampled on in_valid & in_ready.
- b_word  input  W  operand B, sampled on in_valid & in_ready.
- out_valid  output  1  a_bit/b_bit/first/last are valid.
- out_ready  input  1  downstream consumes the current beat.
- a_bit  output  1  current bit of A, LSB first.
- b_bit  output  1  current bit of B, LSB first.
- first  output  1  current beat is bit 0 of the word.
- last  output  1  current beat is bit W-1 of the word.

Behaviour:
- Interface: one clock clk; reset rst is synchronous, active-high.
- State: FSM with IDLE and SHIFT. W-bit shift registers a_sh and b_sh. Bit counter cnt, width max(1, $clog2(W)).
- Reset, and the cycle after rst is deasserted:
  - state = IDLE, cnt = 0, shift registers = 0.
  - out_valid = 0, first = 0, last = 0, a_bit = 0, b_bit = 0.
  - in_ready = 0 while rst is high.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid: load a_sh <= a_word, b_sh <= b_word, cnt <= 0, go to SHIFT.
  - First output beat appears the next cycle (latency 1).
- SHIFT:
  - out_valid = 1; a_bit = a_sh[0]; b_bit = b_sh[0]; first = (cnt == 0); last = (cnt == W-1).
  - On out_ready and not last: shift both registers right by 1 (zero fill), cnt <= cnt + 1.
  - On out_ready and last: the word is complete. If in_valid is high the same cycle, load the new pair, cnt <= 0, stay in SHIFT. Otherwise go to IDLE.
  - Without out_ready: all outputs and state hold unchanged. Outputs must be stable under backpressure.
- in_ready = (state == IDLE) | (state == SHIFT & last & out_ready). This is a combinational out_ready -> in_ready path and is permitted.
- When out_valid = 0, a_bit, b_bit, first and last are forced to 0.
- W = 1: first and last are both asserted on the single beat.
- Reset mid-word: the word is abandoned immediately; the next cycle matches the post-reset state above. No partial beats are emitted afterwards.
- in_valid while in_ready = 0: ignored. Upstream must hold its data until in_ready is seen.
- Inputs are never sampled outside an in_valid & in_ready cycle.

Test Plan:
- Reset check: rst high for 3 cycles with in_valid = 1 -> in_ready = 0 and out_valid = 0 throughout. After release: in_ready = 1, out_valid = 0.
- Basic word, W = 8, out_ready = 1: a = 0x3C, b = 0xA5.
  - out_valid rises 1 cycle after accept.
  - a_bit sequence 0,0,1,1,1,1,0,0.
  - b_bit sequence 1,0,1,0,0,1,0,1.
  - first only on beat 0; last only on beat 7.
  - out_valid = 0 on the following cycle.
- Backpressure: same word, out_ready low on beats 2 and 5 for 3 cycles each -> outputs frozen during stalls, bit sequence unchanged, 14 total valid cycles, exactly 8 accepted beats.
- Back-to-back: pairs (0xFF, 0x01) then (0x80, 0x80), in_valid held high, out_ready = 1.
  - Second pair is accepted on the last beat of the first; no idle cycle.
  - 16 consecutive valid beats; first asserted on beats 0 and 8.
- Reset mid-word: assert rst on beat 3 of a = 0xAA -> out_valid = 0 the next cycle, FSM in IDLE. A new pair (0x0F, 0xF0) then serializes correctly from bit 0.
- W = 1 instance: pairs (1, 0) then (1, 1) -> one beat each, first = last = 1 on every beat, in_ready high on each beat with out_ready = 1.
